// File: rtl/adiabatic_pkg.sv
// ==========================================================================
// Module  : adiabatic_pkg
// Brief   : Shared phase encoding and ramp-level function for the power clocks
// Revision: 1.0
// ==========================================================================
`default_nettype none

package adiabatic_pkg;

  typedef enum logic [1:0] {
    PH_RAMP_UP   = 2'd0,
    PH_HOLD      = 2'd1,
    PH_RAMP_DOWN = 2'd2,
    PH_WAIT      = 2'd3
  } pclk_phase_t;

  function automatic int unsigned pclk_level_f(input pclk_phase_t phase,
                                               input int unsigned cnt,
                                               input int unsigned p);
    case (phase)
      PH_RAMP_UP:   return cnt + 1;
      PH_HOLD:      return p;
      PH_RAMP_DOWN: return p - 1 - cnt;
      default:      return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pclk_stage_level.sv
// ==========================================================================
// Module  : pclk_stage_level
// Brief   : Combinational phase, ramp-level and full-swing decode for one stage
// Revision: 1.0
// ==========================================================================
`default_nettype none

module pclk_stage_level
  import adiabatic_pkg::*;
#(
  parameter int unsigned STAGE        = 0,
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned LW           = 3,
  parameter int unsigned CW           = 2
) (
  input  logic [1:0]    ph,
  input  logic [CW-1:0] cnt,
  input  logic          act,
  output logic [LW-1:0] level,
  output logic          clkpos
);

  pclk_phase_t phase;

  // Each stage lags the master phase by its index, modulo the 4-phase cycle.
  always_comb begin
    phase  = pclk_phase_t'(ph - 2'(STAGE % 4));
    level  = act ? LW'(pclk_level_f(phase, 32'(cnt), PHASE_CYCLES)) : '0;
    clkpos = (level == LW'(PHASE_CYCLES));
  end

endmodule

`default_nettype wire

// File: rtl/adiabatic_pclk_gen.sv
// ==========================================================================
// Module  : adiabatic_pclk_gen
// Brief   : Four-phase power-clock sequencer with rippling per-stage activation
// Revision: 1.0
// ==========================================================================
`default_nettype none

module adiabatic_pclk_gen
  import adiabatic_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned PHASE_CYCLES = 4,
  localparam int unsigned LW          = $clog2(PHASE_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic [NUM_STAGES*LW-1:0]   pclk_level,
  output logic [NUM_STAGES-1:0]      clkpos,
  output logic [NUM_STAGES-1:0]      clkneg,
  output logic                       running,
  output logic                       eval_done
);

  localparam int unsigned    CW       = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0]         cnt, cnt_nxt;
  logic [1:0]            ph, ph_nxt;
  logic [NUM_STAGES-1:0] act, act_nxt;
  logic                  boundary;
  logic                  park_point;
  logic                  advance;
  pclk_phase_t           last_phase;

  always_comb begin
    boundary   = (cnt == CNT_LAST);
    park_point = (ph == 2'd3) && boundary;
    // Idle with nothing to finish: hold at the stage-0 start point.
    advance    = en | (|act) | ~park_point;

    cnt_nxt = cnt;
    ph_nxt  = ph;
    act_nxt = act;
    if (advance) begin
      if (boundary) begin
        cnt_nxt = '0;
        ph_nxt  = ph + 2'd1;
        // A stage may only change activity as it is about to enter RAMP_UP.
        if (ph_nxt == 2'd0) act_nxt[0] = en;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
          if (ph_nxt == 2'(k % 4)) act_nxt[k] = act[k-1];
        end
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_LAST;
      ph  <= 2'd3;
      act <= '0;
    end else begin
      cnt <= cnt_nxt;
      ph  <= ph_nxt;
      act <= act_nxt;
    end
  end

  for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_stage
    pclk_stage_level #(
      .STAGE        (i),
      .PHASE_CYCLES (PHASE_CYCLES),
      .LW           (LW),
      .CW           (CW)
    ) u_stage (
      .ph     (ph),
      .cnt    (cnt),
      .act    (act[i]),
      .level  (pclk_level[i*LW +: LW]),
      .clkpos (clkpos[i])
    );
  end

  always_comb begin
    last_phase = pclk_phase_t'(ph - 2'((NUM_STAGES - 1) % 4));
    clkneg     = ~clkpos;
    running    = |act;
    eval_done  = act[NUM_STAGES-1] && (last_phase == PH_HOLD) && (cnt == '0);
  end

endmodule

`default_nettype wire

// File: tb/tb_adiabatic_pclk_gen.sv
// ==========================================================================
// Module  : tb_adiabatic_pclk_gen
// Brief   : Scoreboard bench for the power-clock sequencer (N=4/P=4, N=5/P=2)
// Revision: 1.1
// ==========================================================================
`default_nettype none

module tb_adiabatic_pclk_gen;

    logic        clk = 1'b0;
    logic        rst, en, rst5, en5;
    logic [11:0] lvl4;
    logic [3:0]  clkpos4, clkneg4;
    logic        running4, eval4;
    logic [9:0]  lvl5;
    logic [4:0]  clkpos5, clkneg5;
    logic        running5, eval5;

    always #5 clk = ~clk;

    adiabatic_pclk_gen #(.NUM_STAGES(4), .PHASE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .pclk_level(lvl4), .clkpos(clkpos4),
        .clkneg(clkneg4), .running(running4), .eval_done(eval4));

    adiabatic_pclk_gen #(.NUM_STAGES(5), .PHASE_CYCLES(2)) dut5 (
        .clk(clk), .rst(rst5), .en(en5), .pclk_level(lvl5), .clkpos(clkpos5),
        .clkneg(clkneg5), .running(running5), .eval_done(eval5));

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   en_hist [64];

    function automatic int sample(int sel);
        if (sel >= 0 && sel <= 3)   return int'(lvl4[sel*3 +: 3]);
        if (sel >= 10 && sel <= 14) return int'(lvl5[(sel-10)*2 +: 2]);
        case (sel)
            4:  return int'(clkpos4);
            5:  return int'(clkneg4);
            6:  return int'(running4);
            7:  return int'(eval4);
            15: return int'(eval5);
            16: return int'(running5);
            17: return int'(clkpos5);
            default: return -1;
        endcase
    endfunction

    // Monitor: every output sampled mid-cycle against whatever was queued.
    exp_t e;
    int   got;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = sample(e.sel);
            tests++;
            if (got != e.exp) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d", e.name, got, e.exp);
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic check_now(input string name, input int got_v, input int exp_v);
        tests++;
        if (got_v != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got_v, exp_v);
        end
    endtask

    task automatic push(input string name, input int sel, input int exp);
        exp_t x;
        x.name = name; x.sel = sel; x.exp = exp;
        sb.push_back(x);
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle4(input int max_cycles);
        int n = 0;
        while (running4 !== 1'b0 && n < max_cycles) begin
            cycle_start();
            n++;
        end
        tests++;
        if (running4 !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle4: running still high after %0d cycles", max_cycles);
        end
    endtask

    // Stage-0 level trace for N=4, P=4, hand-derived from the ramp definition.
    function automatic bit period_on(int n);
        return (n == 0) || en_hist[16*n-1];
    endfunction

    function automatic int lvl4m(int k, int c);
        int s0 [16] = '{1,2,3,4,4,4,4,4,3,2,1,0,0,0,0,0};
        int idx = c - 4*k;
        if (idx < 0 || !period_on(idx / 16)) return 0;
        return s0[idx % 16];
    endfunction

    task automatic expect4(input int c);
        int lv;
        int cp = 0;
        int run = 0;
        int ev;
        int idx3 = c - 12;
        for (int k = 0; k < 4; k++) begin
            lv = lvl4m(k, c);
            push($sformatf("s%0d_level c%0d", k, c), k, lv);
            if (lv == 4) cp |= (1 << k);
            if (c - 4*k >= 0 && period_on((c - 4*k) / 16)) run = 1;
        end
        ev = (idx3 >= 0 && idx3 % 16 == 4 && period_on(idx3 / 16)) ? 1 : 0;
        push($sformatf("clkpos c%0d", c), 4, cp);
        push($sformatf("clkneg c%0d", c), 5, (~cp) & 4'hF);
        push($sformatf("running c%0d", c), 6, run);
        push($sformatf("eval_done c%0d", c), 7, ev);
    endtask

    task automatic expect_reset4(input string tag);
        for (int k = 0; k < 4; k++) push($sformatf("%s s%0d_level", tag, k), k, 0);
        push({tag, " clkpos"}, 4, 0);
        push({tag, " clkneg"}, 5, 15);
        push({tag, " running"}, 6, 0);
        push({tag, " eval_done"}, 7, 0);
    endtask

    task automatic do_reset4();
        rst = 1'b1; en = 1'b0;
        cycle_start(); expect_reset4("rst1");
        check_now("rst1 direct running", int'(running4), 0);
        check_now("rst1 direct clkneg", int'(clkneg4), 15);
        cycle_start(); expect_reset4("rst2");
        check_now("rst2 direct clkpos", int'(clkpos4), 0);
        rst = 1'b0;
        cycle_start(); expect_reset4("parked");
        for (int i = 0; i < 64; i++) en_hist[i] = 1'b0;
    endtask

    initial begin
        int s05 [8] = '{1,2,2,2,1,0,0,0};
        rst = 1'b1; en = 1'b0; rst5 = 1'b1; en5 = 1'b0;

        // Continuous run; en glitch mid-phase must be ignored.
        do_reset4();
        en = 1'b1;
        cycle_start();
        for (int c = 0; c < 40; c++) begin
            expect4(c);
            en = (c == 9) ? 1'b0 : 1'b1;
            en_hist[c] = en;
            cycle_start();
        end

        // Drain: en dropped in cycle 5, then restart from park.
        do_reset4();
        en = 1'b1;
        cycle_start();
        for (int c = 0; c < 34; c++) begin
            expect4(c);
            en = (c < 5) ? 1'b1 : 1'b0;
            en_hist[c] = en;
            cycle_start();
        end
        wait_idle4(40);
        en = 1'b1;
        cycle_start();
        push("restart s0_level", 0, 1);
        push("restart running", 6, 1);
        push("restart s1_level", 1, 0);

        // Mid-run reset during stage-0 HOLD.
        do_reset4();
        en = 1'b1;
        cycle_start();
        for (int c = 0; c < 7; c++) begin
            expect4(c);
            en_hist[c] = 1'b1;
            if (c == 6) rst = 1'b1;
            cycle_start();
        end
        expect_reset4("midrst");
        rst = 1'b0; en = 1'b1;
        cycle_start();
        push("post_rst c0 s0_level", 0, 1);
        push("post_rst c0 running", 6, 1);
        cycle_start();
        push("post_rst c1 s0_level", 0, 2);
        en = 1'b0;

        // N=5, P=2: stage 4 shares stage 0's phase, delayed 8 cycles.
        cycle_start();
        rst5 = 1'b0;
        cycle_start();
        push("n5 parked running", 16, 0);
        push("n5 parked clkpos", 17, 0);
        check_now("n5 parked clkneg", int'(clkneg5), 31);
        en5 = 1'b1;
        cycle_start();
        for (int c = 0; c < 21; c++) begin
            push($sformatf("n5 s0_level c%0d", c), 10, s05[c % 8]);
            push($sformatf("n5 s4_level c%0d", c), 14, (c < 8) ? 0 : s05[(c - 8) % 8]);
            push($sformatf("n5 eval_done c%0d", c), 15, (c == 10 || c == 18) ? 1 : 0);
            push($sformatf("n5 running c%0d", c), 16, 1);
            cycle_start();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adiabatic_pclk_gen.md
# adiabatic_pclk_gen

Digital sequencer for the four-phase power clocks that supply the adiabatic adder cells (PG, gray/black prefix, sum stages). It generates one power-clock per logic stage: stage k lags stage k-1 by one phase. Each stage gets a quantised ramp level for the rail DAC and a full-swing pos/neg pair for switch-level simulation. It sits directly upstream of every gray-cell row and drives its `clkpos`/`clkneg`.

## Interface

- `NUM_STAGES`, 4, number of power-clock stages (≥1).
- `PHASE_CYCLES`, 4, clock cycles per phase (≥2); `LW = $clog2(PHASE_CYCLES+1)`.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `en`  input  1  run request; sampled only at stage-0 period boundaries.
- `pclk_level`  output  NUM_STAGES*LW  per-stage ramp level 0..PHASE_CYCLES; stage k at `[k*LW +: LW]`.
- `clkpos`  output  NUM_STAGES  1 when stage level == PHASE_CYCLES.
- `clkneg`  output  NUM_STAGES  bitwise complement of `clkpos`.
- `running`  output  1  1 while any stage is active.
- `eval_done`  output  1  one-cycle pulse when the last active stage enters HOLD.

## Operation

- Master state: `cnt` (0..P-1, P = PHASE_CYCLES), `ph` (2-bit phase index, wraps 3→0), `act[NUM_STAGES-1:0]`.
- Phase boundary: `cnt == P-1`. At a boundary, `cnt` goes to 0 and `ph` goes to `ph+1`; otherwise `cnt` increments.
- Stage k phase = `(ph - k) mod 4`: 0 RAMP_UP, 1 HOLD, 2 RAMP_DOWN, 3 WAIT.
- Active stage level:
  - RAMP_UP: `cnt+1`
  - HOLD: P
  - RAMP_DOWN: `P-1-cnt`
  - WAIT: 0
- Inactive stage level: 0.
- Activation chain: at a boundary where stage k's next phase is RAMP_UP, `act[k] <= (k==0) ? en : act[k-1]`. All other times `act` holds.
- Consequences:
  - Start and stop ripple down the stages one phase apart.
  - A stage always completes a full period once started.
- Counter advances when `en | (|act) | !(ph==3 && cnt==P-1)`. Otherwise it is parked at `ph=3, cnt=P-1`, which is the stage-0 start point.
- `running = |act`.
- `eval_done` is 1 in exactly one cycle: `act[NUM_STAGES-1]==1`, that stage in HOLD, and `cnt==0`.
- Outputs are derived combinationally from registered state. There are no combinational paths from `en`.

## Timing

- Reset values:
  - `cnt=P-1`, `ph=3`, `act=0`
  - all `pclk_level=0`, `clkpos=0`, `clkneg` all 1
  - `running=0`, `eval_done=0`
- Start: `en=1` sampled at edge E while parked. The cycle after E is cycle 0. From cycle 0, `act[0]=1` and `pclk_level[0]=1`.
- Period: 4P cycles. Stage k starts k·P cycles after stage 0.
- `clkpos[k]` is high for P+1 consecutive cycles: the last RAMP_UP cycle plus all of HOLD.
- Stop: `en=0` at a stage-0 boundary clears `act[0]`. Stage k clears k phases later. `running` falls in the cycle stage N-1's `act` clears, and the counter then coasts to park.
- `en` toggling between boundaries has no effect.
- Re-asserting `en` while draining: `act[0]` is set at the next stage-0 boundary; the drain of the later stages continues as scheduled.
- `rst` mid-operation: all state returns to reset values at the next edge, regardless of phase.
- NUM_STAGES > 4: stage k and stage k+4 share a phase but are separately gated by `act`.

## Structure

- Package `adiabatic_pkg`:
  - `typedef enum logic [1:0] pclk_phase_t {PH_RAMP_UP, PH_HOLD, PH_RAMP_DOWN, PH_WAIT}`
  - level function `pclk_level_f(phase, cnt, P)`
- Sub-module `pclk_stage_level`: combinational per-stage phase/level/clkpos decode, generated NUM_STAGES times.
- Top level holds `cnt`, `ph`, `act`, and the `eval_done` logic.

## Test plan

Scenarios use N=4, P=4 unless stated.

- **Reset:** `rst=1` for 2 cycles → levels 0, `clkpos=0`, `clkneg=4'b1111`, `running=0`, counter parked.
- **Start:** `en=1` from edge E → stage 0 levels over cycles 0–15 are 1,2,3,4,4,4,4,4,3,2,1,0,0,0,0,0. Stage 1 is identical, shifted 4 cycles. `clkpos[0]` is high in cycles 3–7.
- **Last stage:** `en` held high → `eval_done` pulses in cycle 16 only, then every 16 cycles.
- **Drain:** `en` dropped in cycle 5 → stage 0 completes and is 0 from cycle 11 with no restart at 16. Stage 3 completes its period, `running` falls, and the counter parks.
- **Mid-run reset:** `rst` asserted in cycle 6, during stage-0 HOLD → next cycle all outputs are at reset values. `en=1` then restarts with level 1 in cycle 0.
- **Wrap:** N=5, P=2 → stage 4 level trace equals stage 0's delayed 8 cycles. `eval_done` first pulses in cycle 10.
